// File: rtl/lab2_proc_imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into a RISC-V instruction template
// and returns it through a 2-entry in-order val/rdy queue, flagging unrepresentable values.
// Optional range checking is compiled in with `define LAB2_PROC_IMM_ENC_RANGE_CHECK_EN.
module lab2_proc_imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [2:0]  req_imm_type,
    input  logic [31:0] req_inst,
    input  logic [31:0] req_imm,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_BAD6  = 3'd6,
        IMM_BAD7  = 3'd7
    } imm_type_e;

    imm_type_e   w_type;
    logic [31:0] w_enc_inst;
    logic        w_type_err;
    logic        w_range_err;
    logic        w_enc_err;
    logic        w_enq;
    logic        w_deq;
    logic        w_full;
    logic        w_empty;

    logic [31:0] r_mem_inst [2];
    logic        r_mem_err  [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [7:0]  r_err_count;

    assign w_type = imm_type_e'(req_imm_type);

    // Bit placement: every field not written below is copied from the template.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        w_enc_inst = req_inst;
        w_type_err = 1'b0;
        case (w_type)
            IMM_I: begin
                w_enc_inst[31:20] = req_imm[11:0];
            end
            IMM_S: begin
                w_enc_inst[31:25] = req_imm[11:5];
                w_enc_inst[11:7]  = req_imm[4:0];
            end
            IMM_B: begin
                w_enc_inst[31]    = req_imm[12];
                w_enc_inst[30:25] = req_imm[10:5];
                w_enc_inst[11:8]  = req_imm[4:1];
                w_enc_inst[7]     = req_imm[11];
            end
            IMM_U: begin
                w_enc_inst[31:12] = req_imm[31:12];
            end
            IMM_J: begin
                w_enc_inst[31]    = req_imm[20];
                w_enc_inst[30:21] = req_imm[10:1];
                w_enc_inst[20]    = req_imm[11];
                w_enc_inst[19:12] = req_imm[19:12];
            end
            IMM_SHAMT: begin
                w_enc_inst[24:20] = req_imm[4:0];
            end
            default: begin
                w_type_err = 1'b1;
            end
        endcase
    end

`ifdef LAB2_PROC_IMM_ENC_RANGE_CHECK_EN
    // A value fits an N-bit signed field when all bits above the field's sign bit match it.
    always_comb begin
        w_range_err = 1'b0;
        case (w_type)
            IMM_I, IMM_S: begin
                w_range_err = (req_imm[31:11] != '0) && (req_imm[31:11] != '1);
            end
            IMM_B: begin
                w_range_err = ((req_imm[31:12] != '0) && (req_imm[31:12] != '1))
                              || req_imm[0];
            end
            IMM_U: begin
                w_range_err = (req_imm[11:0] != '0);
            end
            IMM_J: begin
                w_range_err = ((req_imm[31:20] != '0) && (req_imm[31:20] != '1))
                              || req_imm[0];
            end
            IMM_SHAMT: begin
                w_range_err = (req_imm[31:5] != '0);
            end
            default: begin
                w_range_err = 1'b0;
            end
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign w_enc_err = w_type_err | w_range_err;

    // Handshake: ready depends only on occupancy, never on resp_rdy.
    assign w_full   = (r_count == 2'd2);
    assign w_empty  = (r_count == 2'd0);
    assign req_rdy  = !reset && !w_full;
    assign resp_val = !w_empty;
    assign w_enq    = req_val && req_rdy;
    assign w_deq    = resp_val && resp_rdy;

    assign resp_inst = r_mem_inst[r_rd_ptr];
    assign resp_err  = r_mem_err[r_rd_ptr];
    assign err_count = r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the two storage entries are reset because resp_inst/resp_err read them
            // directly and must show zero out of reset; a deep RAM would be left unreset.
            for (int i = 0; i < 2; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_err[i]  <= 1'b0;
            end
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_err_count <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_enq) begin
                r_mem_inst[r_wr_ptr] <= w_enc_inst;
                r_mem_err[r_wr_ptr]  <= w_enc_err;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // Count errored responses as they leave; stick at 255.
            if (w_deq && resp_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lab2_proc_imm_encoder.sv
// Scoreboard bench for lab2_proc_imm_encoder: driver pushes expected {inst, err} on accept,
// a negedge monitor pops and compares on every dequeue.
module tb_lab2_proc_imm_encoder;

`ifdef LAB2_PROC_IMM_ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_imm_type;
    logic [31:0] req_inst;
    logic [31:0] req_imm;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] sb [$];

    lab2_proc_imm_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_imm_type (req_imm_type),
        .req_inst     (req_inst),
        .req_imm      (req_imm),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_inst    (resp_inst),
        .resp_err     (resp_err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every dequeue must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && resp_val === 1'b1 && resp_rdy) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got inst 0x%08h err %0b, expected none", resp_inst, resp_err);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("resp_inst", resp_inst, e[32:1]);
                check("resp_err", {31'd0, resp_err}, {31'd0, e[0]});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [2:0] t, input logic [31:0] inst, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic exp_err);
        int waited = 0;
        bit ok = 1'b1;
        req_val = 1'b1;
        req_imm_type = t;
        req_inst = inst;
        req_imm = imm;
        while (1) begin
            @(negedge clk);
            if (req_rdy === 1'b1) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: req_rdy stuck at %b, expected 1", req_rdy);
                ok = 1'b0;
                break;
            end
        end
        @(posedge clk);
        if (ok) sb.push_back({exp_inst, exp_err});
        #1 req_val = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (1) begin
            @(negedge clk);
            if (sb.size() == 0 && resp_val === 1'b0) break;
            waited++;
            if (waited > 500) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_val = 1'b0;
        req_imm_type = 3'd0;
        req_inst = 32'd0;
        req_imm = 32'd0;
        resp_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
        check("rst_resp_val", {31'd0, resp_val}, 32'd0);
        check("rst_resp_inst", resp_inst, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        @(posedge clk);
        #1;

        // Directed encodings
        send(3'd0, 32'h00000093, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        send(3'd0, 32'h00000093, 32'h00000800, 32'h80000093, RC);
        send(3'd1, 32'h00002023, 32'hFFFFFFF8, 32'hFE002C23, 1'b0);
        send(3'd2, 32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        send(3'd2, 32'h00000063, 32'h00000008, 32'h00000463, 1'b0);
        send(3'd2, 32'h00000063, 32'h00000003, 32'h00000163, RC);
        send(3'd3, 32'h00000037, 32'h12345000, 32'h12345037, 1'b0);
        send(3'd4, 32'h0000006F, 32'h00000800, 32'h0010006F, 1'b0);
        send(3'd4, 32'h0000006F, 32'h00100000, 32'h8000006F, RC);
        send(3'd5, 32'h00001013, 32'd31, 32'h01F01013, 1'b0);
        send(3'd5, 32'h00001013, 32'd32, 32'h00001013, RC);
        send(3'd7, 32'h00001013, 32'd5, 32'h00001013, 1'b1);
        drain();
        check("err_count_directed", {24'd0, err_count}, RC ? 32'd5 : 32'd1);

        // Backpressure: two fill the queue, third waits for space
        resp_rdy = 1'b0;
        send(3'd0, 32'h00000093, 32'd1, 32'h00100093, 1'b0);
        send(3'd0, 32'h00000093, 32'd2, 32'h00200093, 1'b0);
        @(negedge clk);
        check("bp_full_req_rdy", {31'd0, req_rdy}, 32'd0);
        check("bp_resp_val", {31'd0, resp_val}, 32'd1);
        @(posedge clk);
        #1;
        fork
            send(3'd0, 32'h00000093, 32'd3, 32'h00300093, 1'b0);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("bp_hold_req_rdy", {31'd0, req_rdy}, 32'd0);
                    check("bp_hold_inst", resp_inst, 32'h00100093);
                end
                @(posedge clk);
                #1 resp_rdy = 1'b1;
            end
        join
        drain();

        // Mid-operation reset with two entries queued
        resp_rdy = 1'b0;
        send(3'd6, 32'h00000037, 32'd0, 32'h00000037, 1'b1);
        send(3'd0, 32'h00000093, 32'd4, 32'h00400093, 1'b0);
        #1 reset = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_resp_val", {31'd0, resp_val}, 32'd0);
        check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        check("mid_rst_resp_inst", resp_inst, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        resp_rdy = 1'b1;
        req_val = 1'b1;
        req_imm_type = 3'd0;
        req_inst = 32'h00000093;
        req_imm = 32'd9;
        @(negedge clk);
        check("enq_cycle_no_bypass", {31'd0, resp_val}, 32'd0);
        check("enq_cycle_req_rdy", {31'd0, req_rdy}, 32'd1);
        @(posedge clk);
        sb.push_back({32'h00900093, 1'b0});
        #1 req_val = 1'b0;
        @(negedge clk);
        check("latency_resp_val", {31'd0, resp_val}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("alone_resp_val", {31'd0, resp_val}, 32'd0);
        @(posedge clk);
        #1;

        // Saturating error counter
        for (int i = 0; i < 254; i++) begin
            if (RC) send(3'd3, 32'h00000037, 32'h00000001, 32'h00000037, 1'b1);
            else    send(3'd6, 32'h00000037, 32'h00000001, 32'h00000037, 1'b1);
        end
        drain();
        check("err_count_254", {24'd0, err_count}, 32'd254);
        for (int i = 0; i < 6; i++) begin
            if (RC) send(3'd3, 32'h00000037, 32'h00000001, 32'h00000037, 1'b1);
            else    send(3'd6, 32'h00000037, 32'h00000001, 32'h00000037, 1'b1);
            if (i == 0) begin
                drain();
                check("err_count_255", {24'd0, err_count}, 32'd255);
            end
        end
        drain();
        check("err_count_sat", {24'd0, err_count}, 32'd255);
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
